uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_TX serializer among NUM_REQ byte producers. Round-robin grants one requester per frame,
//  drives P_DATA/Data_Valid and parity config into UART_TX, and tracks its busy output to sequence frames.
//  Sits directly in front of UART_TX; requesters never touch the UART handshake.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  DATA_WIDTH  8      byte width; must match UART_TX DATA_WIDTH
//  WDOG_CYCLES 4096   watchdog limit on tx_busy high (only with UART_ARB_WDOG_EN)
// PORTS
//  CLK            in   1                    clock, single domain
//  RST            in   1                    reset, synchronous, active-high
//  req            in   NUM_REQ              per-requester "byte pending"; held until ack
//  req_data       in   NUM_REQ*DATA_WIDTH   requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_par_en     in   NUM_REQ              per-requester parity enable
//  req_par_type   in   NUM_REQ              per-requester parity type (0 even, 1 odd)
//  ack            out  NUM_REQ              one-cycle pulse: requester byte taken
//  tx_p_data      out  DATA_WIDTH           to UART_TX P_DATA
//  tx_data_valid  out  1                    to UART_TX Data_Valid (single-cycle pulse)
//  tx_par_en      out  1                    to UART_TX parity_enable; stable for whole frame
//  tx_par_type    out  1                    to UART_TX parity_type; stable for whole frame
//  tx_busy        in   1                    from UART_TX busy
//  grant_id       out  $clog2(NUM_REQ)      index of requester owning current frame
//  arb_busy       out  1                    high in any state except IDLE
//  wdog_err       out  1                    sticky watchdog flag (only with UART_ARB_WDOG_EN)
// BEHAVIOUR
//  Reset (RST=1 at posedge): state=IDLE, ack=0, tx_p_data=0, tx_data_valid=0, tx_par_en=0, tx_par_type=0,
//   grant_id=0, arb_busy=0, wdog_err=0, rr pointer last=NUM_REQ-1 (requester 0 wins first). Reset mid-frame
//   aborts immediately; no ack issued for the aborted grant.
//  FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   IDLE: if |req and !tx_busy: pick first set req searching last+1, last+2,... (mod NUM_REQ); register
//    its byte/parity into tx_* regs, grant_id=pick, last=pick, ack[pick]=1 for this one cycle; -> LAUNCH.
//    If tx_busy high in IDLE (foreign/early frame), stay IDLE.
//   LAUNCH: tx_data_valid=1 exactly this cycle; -> WAIT_BUSY.
//   WAIT_BUSY: wait tx_busy=1 -> WAIT_DONE.
//   WAIT_DONE: wait tx_busy=0 -> IDLE. Next grant earliest the following cycle (min 1 idle gap).
//  Latency: req rise in IDLE -> ack next edge; tx_data_valid one cycle after ack.
//  tx_p_data/tx_par_en/tx_par_type hold from LAUNCH until next grant (UART config never changes mid-frame).
//  req deasserted before ack: no grant (requesters must hold; no glitch detection). req changes on
//   non-granted lines during a frame have no effect. All req high continuously: grants 0,1,2,3,0,...
//  grant_id holds last granted index while IDLE.
// CONFIGURATION
//  UART_ARB_WDOG_EN defined: counter runs in WAIT_BUSY and WAIT_DONE; if WAIT_BUSY exceeds 3 cycles or
//   WAIT_DONE exceeds WDOG_CYCLES, set wdog_err=1 (sticky until RST), go IDLE; rr pointer still advances.
//  Undefined: no counter; wdog_err tied 0; FSM waits on tx_busy indefinitely.
// STRUCTURE
//  Package uart_tx_arb_pkg: state encoding localparams (IDLE=2'd0,LAUNCH=2'd1,WAIT_BUSY=2'd2,
//   WAIT_DONE=2'd3), IDX_W = $clog2(NUM_REQ) helper.
//  Sub-module uart_tx_rr_pick: combinational rotate-priority search (req, last) -> (pick, found).
//  Top holds FSM, capture regs, optional watchdog.
// TESTING (bench instantiates UART_TX behind the arbiter, par via req_par_*)
//  Single req[2]=1, data 8'hA5, par_en=1 type=0 -> ack[2] 1 cycle, Data_Valid 1 cycle, TX_OUT frame
//   0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first, parity 0, stop); grant_id=2.
//  req=4'b1111 held, data 8'h10..8'h13 -> frames emitted in order 8'h10,11,12,13,10; never overlap.
//  req[0] par_en=0, req[1] par_en=1 type=1, back-to-back -> frame lengths 10 then 11 bits; tx_par_* flip
//   only in IDLE.
//  RST asserted 4 cycles into WAIT_DONE -> all outputs to reset values next edge; next grant goes to req 0.
//  tx_busy forced high in IDLE with req[1]=1 -> no ack until tx_busy low, then ack[1].
//  UART_ARB_WDOG_EN, tx_busy stuck 0 after LAUNCH -> wdog_err=1 after 3 WAIT_BUSY cycles, FSM IDLE.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Cycles the UART may take to raise busy after Data_Valid before the watchdog trips.
    localparam int WB_LIMIT = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART_TX handshake bundle; master = arbiter side, slave = requesters + UART_TX side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            req_par_type;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_data_valid;
    logic                          tx_par_en;
    logic                          tx_par_type;
    logic                          tx_busy;

    modport master (
        input  req, req_data, req_par_en, req_par_type, tx_busy,
        output ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_type
    );

    modport slave (
        output req, req_data, req_par_en, req_par_type, tx_busy,
        input  ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_type
    );
endinterface

// File: rtl/uart_tx_rr_pick.sv
// Rotating-priority search: first set req after 'last', wrapping modulo NUM_REQ.
module uart_tx_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   pick,
    output logic               found
);
    localparam int unsigned NR = unsigned'(NUM_REQ);

    // Scan from the farthest candidate back to last+1 so the nearest hit overwrites.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = NR; k >= 1; k--) begin
            idx = (32'(last) + k) % NR;
            if (req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers.
// Optional watchdog on the UART busy handshake: define UART_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int WDOG_CYCLES = 4096,
    localparam int IDX_W       = idx_w(NUM_REQ)
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_arbiter_if.master bus,
    output logic [IDX_W-1:0]  grant_id,
    output logic              arb_busy,
    output logic              wdog_err
);
    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] pick;
    logic             found;

    uart_tx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req),
        .last  (last),
        .pick  (pick),
        .found (found)
    );

    assign arb_busy = (state != IDLE);

`ifdef UART_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign wdog_err = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= IDLE;
            last              <= IDX_W'(NUM_REQ - 1);
            grant_id          <= '0;
            bus.ack           <= '0;
            bus.tx_p_data     <= '0;
            bus.tx_data_valid <= 1'b0;
            bus.tx_par_en     <= 1'b0;
            bus.tx_par_type   <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            wd_cnt            <= '0;
            wdog_err          <= 1'b0;
`endif
        end else begin
            bus.ack           <= '0;
            bus.tx_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !bus.tx_busy) begin
                        bus.tx_p_data   <= bus.req_data[32'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        bus.tx_par_en   <= bus.req_par_en[pick];
                        bus.tx_par_type <= bus.req_par_type[pick];
                        bus.ack         <= NUM_REQ'(1) << pick;
                        grant_id        <= pick;
                        last            <= pick;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.tx_data_valid <= 1'b1;
                    state             <= WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
                    wd_cnt            <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state  <= WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(WB_LIMIT - 1)) begin
                        wdog_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
`ifdef UART_ARB_WDOG_EN
                    end else if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                        wdog_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
